// File: rtl/avl_axi_stream_downsizer.sv
// AXI-Stream width downsizer: one wide beat in, RATIO narrow slices out.
// The least significant slice goes first. Slices with no kept bytes are
// skipped. A beat with no kept bytes and tlast=1 still yields one empty
// slice, so that the packet boundary is preserved.
module avl_axi_stream_downsizer #(
   parameter int S_TDATA_WIDTH = 32,
   parameter int M_TDATA_WIDTH = 8,
   parameter int TID_WIDTH     = 1,
   parameter int TDEST_WIDTH   = 1,
   parameter int TUSER_WIDTH   = 1
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   input  logic [S_TDATA_WIDTH-1:0]   s_tdata,
   input  logic [S_TDATA_WIDTH/8-1:0] s_tstrb,
   input  logic [S_TDATA_WIDTH/8-1:0] s_tkeep,
   input  logic                       s_tlast,
   input  logic [TID_WIDTH-1:0]       s_tid,
   input  logic [TDEST_WIDTH-1:0]     s_tdest,
   input  logic [TUSER_WIDTH-1:0]     s_tuser,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic [M_TDATA_WIDTH-1:0]   m_tdata,
   output logic [M_TDATA_WIDTH/8-1:0] m_tstrb,
   output logic [M_TDATA_WIDTH/8-1:0] m_tkeep,
   output logic                       m_tlast,
   output logic [TID_WIDTH-1:0]       m_tid,
   output logic [TDEST_WIDTH-1:0]     m_tdest,
   output logic [TUSER_WIDTH-1:0]     m_tuser
);

   localparam int RATIO = S_TDATA_WIDTH / M_TDATA_WIDTH;
   localparam int SKW   = S_TDATA_WIDTH / 8;
   localparam int MKW   = M_TDATA_WIDTH / 8;
   localparam int IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;

   generate
      if ((S_TDATA_WIDTH % 8 != 0) || (M_TDATA_WIDTH % 8 != 0) || (M_TDATA_WIDTH < 8) ||
          (S_TDATA_WIDTH % M_TDATA_WIDTH != 0) || (RATIO < 2) ||
          (TID_WIDTH < 1) || (TDEST_WIDTH < 1) || (TUSER_WIDTH < 1)) begin : g_bad_params
         $fatal(1, "avl_axi_stream_downsizer: illegal width combination");
      end
   endgenerate

   typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

   state_t                    state, state_nxt;
   logic [IDXW-1:0]           idx, idx_nxt;
   logic                      load;

   logic [S_TDATA_WIDTH-1:0]  held_data;
   logic [SKW-1:0]            held_strb;
   logic [SKW-1:0]            held_keep;
   logic                      held_last;
   logic [TID_WIDTH-1:0]      held_id;
   logic [TDEST_WIDTH-1:0]    held_dest;
   logic [TUSER_WIDTH-1:0]    held_user;

   logic [RATIO-1:0]          held_kept, new_kept;
   logic                      is_final, new_any;
   logic [IDXW-1:0]           next_idx, first_idx;
   logic                      pop, push;

   // Per-slice "has any kept byte" flags for the held beat and the incoming beat
   always_comb begin
      held_kept = '0;
      new_kept  = '0;
      for (int i = 0; i < RATIO; i++) begin
         held_kept[i] = |held_keep[i*MKW +: MKW];
         new_kept[i]  = |s_tkeep[i*MKW +: MKW];
      end
   end

   // Slice search: lowest kept slice above idx (and whether one exists), plus the first kept slice of the incoming beat
   always_comb begin
      is_final  = 1'b1;
      next_idx  = idx;
      new_any   = 1'b0;
      first_idx = '0;
      for (int i = RATIO - 1; i >= 0; i--) begin
         if (i > int'(idx) && held_kept[i]) begin
            is_final = 1'b0;
            next_idx = IDXW'(i);
         end
         if (new_kept[i]) begin
            new_any   = 1'b1;
            first_idx = IDXW'(i);
         end
      end
   end

   // State register: holding flag and current slice index
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= EMPTY;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next state: advance through kept slices, and refill from the slave on the final slice or when empty
   always_comb begin
      pop       = (state == SEND) && m_tready;
      push      = s_tvalid && s_tready;
      state_nxt = state;
      idx_nxt   = idx;
      load      = 1'b0;
      if (pop) begin
         if (is_final) state_nxt = EMPTY;
         else          idx_nxt   = next_idx;
      end
      if (push) begin
         load = 1'b1;
         if (new_any) begin
            state_nxt = SEND;
            idx_nxt   = first_idx;
         end else if (s_tlast) begin
            // Nothing kept, but the packet end still has to be signalled downstream
            state_nxt = SEND;
            idx_nxt   = '0;
         end else begin
            state_nxt = EMPTY;
         end
      end
   end

   // Beat holding register; its contents stay frozen until the next accepted beat
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         held_data <= '0;
         held_strb <= '0;
         held_keep <= '0;
         held_last <= 1'b0;
         held_id   <= '0;
         held_dest <= '0;
         held_user <= '0;
      end else if (load) begin
         held_data <= s_tdata;
         held_strb <= s_tstrb;
         held_keep <= s_tkeep;
         held_last <= s_tlast;
         held_id   <= s_tid;
         held_dest <= s_tdest;
         held_user <= s_tuser;
      end
   end

   // Outputs: slice select from registered state; s_tready opens combinationally on the final handshake
   always_comb begin
      m_tvalid = (state == SEND);
      s_tready = !areset && ((state == EMPTY) || (pop && is_final));
      m_tdata  = held_data[idx*M_TDATA_WIDTH +: M_TDATA_WIDTH];
      m_tstrb  = held_strb[idx*MKW +: MKW];
      m_tkeep  = held_keep[idx*MKW +: MKW];
      m_tlast  = held_last && is_final;
      m_tid    = held_id;
      m_tdest  = held_dest;
      m_tuser  = held_user;
   end

endmodule

// File: tb/tb_avl_axi_stream_downsizer.sv
// Scoreboard bench for avl_axi_stream_downsizer (32 -> 8 bits).
module tb_avl_axi_stream_downsizer;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [31:0] s_tdata = '0;
   logic [3:0]  s_tstrb = '0;
   logic [3:0]  s_tkeep = '0;
   logic        s_tlast = 1'b0;
   logic [1:0]  s_tid = '0;
   logic [2:0]  s_tdest = '0;
   logic [1:0]  s_tuser = '0;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic [7:0]  m_tdata;
   logic [0:0]  m_tstrb;
   logic [0:0]  m_tkeep;
   logic        m_tlast;
   logic [1:0]  m_tid;
   logic [2:0]  m_tdest;
   logic [1:0]  m_tuser;

   avl_axi_stream_downsizer #(
      .S_TDATA_WIDTH(32), .M_TDATA_WIDTH(8),
      .TID_WIDTH(2), .TDEST_WIDTH(3), .TUSER_WIDTH(2)
   ) dut (
      .aclk(aclk), .areset(areset),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
      .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
      .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser)
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [7:0] d;
      logic       k;
      logic       s;
      logic       l;
      logic       fin;
      logic [1:0] id;
      logic [2:0] dst;
      logic [1:0] u;
   } exp_t;

   exp_t sb[$];
   int   pops[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic exp(input logic [7:0] d, input logic k, input logic s, input logic l,
                      input logic fin, input logic [1:0] id, input logic [2:0] dst, input logic [1:0] u);
      exp_t e;
      e.d = d; e.k = k; e.s = s; e.l = l; e.fin = fin; e.id = id; e.dst = dst; e.u = u;
      sb.push_back(e);
   endtask

   // Expected slices for one beat, used where the stream is too long to list by hand
   task automatic model(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s, input logic l,
                        input logic [1:0] id, input logic [2:0] dst, input logic [1:0] u);
      int lk = -1;
      for (int i = 0; i < 4; i++) if (k[i]) lk = i;
      if (lk < 0) begin
         if (l) exp(d[7:0], 1'b0, s[0], 1'b1, 1'b1, id, dst, u);
      end else begin
         for (int i = 0; i < 4; i++)
            if (k[i]) exp(d[8*i +: 8], 1'b1, s[i], l && (i == lk), i == lk, id, dst, u);
      end
   endtask

   // Drive one beat and hold it until the slave handshake completes
   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s, input logic l,
                       input logic [1:0] id, input logic [2:0] dst, input logic [1:0] u);
      logic hs;
      int   n = 0;
      s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tstrb = s; s_tlast = l;
      s_tid = id; s_tdest = dst; s_tuser = u;
      forever begin
         @(negedge aclk);
         hs = s_tready;
         @(posedge aclk);
         #1;
         if (hs) break;
         n++;
         if (n > 300) begin
            chk("send_timeout", 32'(n), 32'd0);
            break;
         end
      end
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge aclk);
         n++;
      end
      chk("drain_queue_empty", 32'(sb.size()), 32'd0);
      @(posedge aclk);
      #1;
   endtask

   // Monitor: compares every master handshake against the scoreboard, checks s_tready and stall stability
   logic [18:0] snap;
   logic        prev_stall = 1'b0;
   always @(negedge aclk) begin
      exp_t e;
      if (areset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("stall_stable", 32'({m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser}),
                32'(snap));
         if (m_tvalid) begin
            if (sb.size() == 0) begin
               chk("unexpected_slice", 32'(m_tdata), 32'hFFFF_FFFF);
            end else begin
               e = sb[0];
               chk("s_tready_busy", 32'(s_tready), 32'(m_tready && e.fin));
               if (m_tready) begin
                  e = sb.pop_front();
                  chk("slice", 32'({m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser}),
                      32'({e.d, e.k, e.s, e.l, e.id, e.dst, e.u}));
                  pops.push_back(cyc);
               end
            end
         end else begin
            chk("s_tready_idle", 32'(s_tready), 32'd1);
         end
         prev_stall = m_tvalid && !m_tready;
         snap = {m_tvalid, m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser};
      end
   end

   initial begin
      bit done;
      // Reset state
      #12;
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_m_outputs", 32'({m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tdest, m_tuser}), 32'd0);
      @(posedge aclk); #1;
      areset = 1'b0;
      m_tready = 1'b1;
      @(posedge aclk); #1;

      // Full beat, LSB slice first, tlast only on the top slice, no gaps
      pops.delete();
      exp(8'hAA, 1, 1, 0, 0, 2'd2, 3'd5, 2'd1);
      exp(8'hBB, 1, 1, 0, 0, 2'd2, 3'd5, 2'd1);
      exp(8'hCC, 1, 1, 0, 0, 2'd2, 3'd5, 2'd1);
      exp(8'hDD, 1, 1, 1, 1, 2'd2, 3'd5, 2'd1);
      send(32'hDDCCBBAA, 4'hF, 4'hF, 1'b1, 2'd2, 3'd5, 2'd1);
      drain();
      chk("t1_pop_count", 32'(pops.size()), 32'd4);
      if (pops.size() == 4) chk("t1_consecutive", 32'(pops[3] - pops[0]), 32'd3);

      // Three back-to-back full beats: 12 slices with no bubble
      pops.delete();
      model(32'h03020100, 4'hF, 4'hF, 1'b0, 2'd1, 3'd1, 2'd0);
      model(32'h07060504, 4'hF, 4'hF, 1'b0, 2'd1, 3'd1, 2'd0);
      model(32'h0B0A0908, 4'hF, 4'hF, 1'b1, 2'd1, 3'd1, 2'd0);
      send(32'h03020100, 4'hF, 4'hF, 1'b0, 2'd1, 3'd1, 2'd0);
      send(32'h07060504, 4'hF, 4'hF, 1'b0, 2'd1, 3'd1, 2'd0);
      send(32'h0B0A0908, 4'hF, 4'hF, 1'b1, 2'd1, 3'd1, 2'd0);
      drain();
      chk("t2_pop_count", 32'(pops.size()), 32'd12);
      if (pops.size() == 12) chk("t2_no_gap", 32'(pops[11] - pops[0]), 32'd11);

      // Sparse keep 1010: slices 1 and 3 only
      pops.delete();
      exp(8'h22, 1, 1, 0, 0, 2'd3, 3'd7, 2'd3);
      exp(8'h44, 1, 0, 1, 1, 2'd3, 3'd7, 2'd3);
      send(32'h44332211, 4'b1010, 4'b0010, 1'b1, 2'd3, 3'd7, 2'd3);
      drain();
      chk("t3_pop_count", 32'(pops.size()), 32'd2);

      // Null beat without tlast is consumed silently
      pops.delete();
      send(32'h12345678, 4'h0, 4'h0, 1'b0, 2'd0, 3'd2, 2'd2);
      repeat (5) @(posedge aclk);
      #1;
      chk("t4_no_slices", 32'(pops.size()), 32'd0);

      // Null beat with tlast: one empty slice carrying tlast
      exp(8'h21, 0, 0, 1, 1, 2'd1, 3'd3, 2'd2);
      send(32'h87654321, 4'h0, 4'h0, 1'b1, 2'd1, 3'd3, 2'd2);
      drain();
      chk("t5_pop_count", 32'(pops.size()), 32'd1);

      // Random 50% backpressure over a mix of keep patterns
      pops.delete();
      done = 1'b0;
      fork
         begin
            model(32'hF3F2F1F0, 4'hF, 4'h5, 1'b0, 2'd0, 3'd4, 2'd1);
            model(32'hE3E2E1E0, 4'b0110, 4'hF, 1'b0, 2'd0, 3'd4, 2'd1);
            model(32'hD3D2D1D0, 4'b1000, 4'hF, 1'b1, 2'd2, 3'd6, 2'd3);
            model(32'hC3C2C1C0, 4'b0001, 4'h1, 1'b1, 2'd1, 3'd0, 2'd0);
            model(32'hB3B2B1B0, 4'b1001, 4'h9, 1'b1, 2'd3, 3'd2, 2'd2);
            send(32'hF3F2F1F0, 4'hF, 4'h5, 1'b0, 2'd0, 3'd4, 2'd1);
            send(32'hE3E2E1E0, 4'b0110, 4'hF, 1'b0, 2'd0, 3'd4, 2'd1);
            send(32'hD3D2D1D0, 4'b1000, 4'hF, 1'b1, 2'd2, 3'd6, 2'd3);
            send(32'hC3C2C1C0, 4'b0001, 4'h1, 1'b1, 2'd1, 3'd0, 2'd0);
            send(32'hB3B2B1B0, 4'b1001, 4'h9, 1'b1, 2'd3, 3'd2, 2'd2);
            drain();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge aclk);
               #1;
               m_tready = 1'($urandom_range(0, 1));
            end
         end
      join
      m_tready = 1'b1;
      chk("t6_pop_count", 32'(pops.size()), 32'd10);
      @(posedge aclk); #1;

      // Reset pulsed while slice 2 of 4 is on the bus
      exp(8'h10, 1, 1, 0, 0, 2'd0, 3'd1, 2'd0);
      exp(8'h20, 1, 1, 0, 0, 2'd0, 3'd1, 2'd0);
      send(32'h40302010, 4'hF, 4'hF, 1'b1, 2'd0, 3'd1, 2'd0);
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      chk("t7_slice2_valid", 32'({m_tvalid, m_tdata}), 32'h130);
      #2;
      areset = 1'b1;
      #1;
      chk("t7_async_tvalid", 32'(m_tvalid), 32'd0);
      chk("t7_async_tready", 32'(s_tready), 32'd0);
      chk("t7_sb_empty", 32'(sb.size()), 32'd0);
      sb.delete();
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      areset = 1'b0;
      chk("t7_post_rst_outputs", 32'({m_tvalid, m_tdata, m_tlast}), 32'd0);
      pops.delete();
      exp(8'hB2, 1, 1, 0, 0, 2'd2, 3'd3, 2'd1);
      exp(8'hA1, 1, 1, 1, 1, 2'd2, 3'd3, 2'd1);
      send(32'hA1B2C3D4, 4'b1100, 4'hF, 1'b1, 2'd2, 3'd3, 2'd1);
      drain();
      chk("t7_pop_count", 32'(pops.size()), 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
